ram_share_ctrl: RTL and testbench
=================================

Name: ram_share_ctrl

Overview:
- Controller that shares one single-port ram32x4 (registered address/data/wren, q one clock after the sampling edge) between two requesters, A and B.
- After reset it clears every word to zero, then grants accesses with a round-robin arbiter, one access per cycle.
- Read data returns with a fixed latency and carries a per-client valid flag.
- Sits between user-facing logic (switch input, display scanner) and the ram32x4 instance.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32
- DATA_W, 4, data word width
- READ_LAT, 2, cycles from transfer cycle to rvalid (fixed by ram32x4 timing; not for retuning)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_req  in  1  client A requests an access
- a_we  in  1  client A: 1 = write, 0 = read
- a_addr  in  ADDR_W  client A address
- a_din  in  DATA_W  client A write data
- a_gnt  out  1  client A access accepted this cycle
- a_rvalid  out  1  rdata holds client A read result
- b_req, b_we, b_addr, b_din, b_gnt, b_rvalid: same as the A ports, for client B
- rdata  out  DATA_W  read data, shared by both clients
- busy  out  1  clear sequence in progress
- mem_addr  out  ADDR_W  to ram32x4 address
- mem_din  out  DATA_W  to ram32x4 data
- mem_we  out  1  to ram32x4 wren
- mem_dout  in  DATA_W  from ram32x4 q

Behaviour:
- Reset, while high and on the first cycle after: busy=1; a_gnt, b_gnt, a_rvalid, b_rvalid = 0; mem_we=0; mem_addr=0; mem_din=0; read pipeline flushed; RR pointer favours A; FSM enters CLEAR with clear counter = 0.
- CLEAR:
  - Each cycle registers mem_we=1, mem_addr=counter, mem_din=0, then increments the counter.
  - After address DEPTH-1 is issued, moves to SERVE; busy drops the cycle after the last clear write is registered.
  - Total is exactly 32 cycles of busy after reset falls.
  - Grants are 0 throughout; requests are ignored, not queued.
- SERVE:
  - gnt is combinational: x_gnt = x_req AND selected AND state==SERVE.
  - Transfer happens in a cycle where req & gnt = 1; the requester must hold we/addr/din stable until that cycle.
  - At the edge ending the transfer cycle, mem_addr, mem_din and mem_we are registered from the winning client. With no transfer, mem_we=0 and mem_addr/mem_din hold their values.
- Arbitration:
  - Only one client requesting: it wins every cycle, giving back-to-back throughput.
  - Both requesting: the client not granted last wins; the pointer updates only on a transfer.
- Reads:
  - A read transfer in cycle t gives x_rvalid=1 for exactly cycle t+2, with rdata = mem_dout in that cycle.
  - rvalid pipeline: 2-stage shift of {valid, client_id}.
  - rdata is mem_dout passed through; it is don't-care while both rvalid are 0.
  - Writes never produce rvalid.
- Read-after-write: write in cycle t, read of the same address in cycle t+1 or later returns the new data. No forwarding is needed because ram32x4 samples the write one edge earlier.
- Collision: A and B can never access in the same cycle, so a same-address conflict is impossible.
- Reset mid-operation: in-flight reads are dropped (no rvalid) and CLEAR restarts from address 0. Reset has priority over all events.
- Address arithmetic: the clear counter is ADDR_W+1 bits so termination is detected without wrap. Client addresses are used unmodified.

Decomposition:
- Package ram_share_pkg:
  - ADDR_W, DATA_W, DEPTH, READ_LAT constants
  - state_t enum {CLEAR, SERVE}
  - client_t enum {CLI_A, CLI_B}
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: clk, reset, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - Pointer resets to favour A.
- Top level holds the FSM, clear counter, mem registers and rvalid pipeline.
- Bench instantiates the real ram32x4 behind the controller.

Test Plan:
- Clear check: release reset -> busy=1 for 32 cycles, mem_we=1 with mem_addr 0..31 and mem_din=0; after busy falls, A reads addr 17 -> a_rvalid two cycles later with rdata=0.
- Single client: A writes 10@17, 9@25, 4@13 back-to-back, a_gnt high every cycle; A then reads 17, 25, 13 back-to-back -> a_rvalid three consecutive cycles with rdata 10, 9, 4.
- Contention: A and B both hold req, A writing 5@27, B reading 27 -> grants alternate starting with A; B's read returns 5; A's second write is granted on the third cycle.
- Tagging: A reads 1 (holding 11), B reads 6 (holding 15) on alternating grants -> a_rvalid and b_rvalid never both high; each pairs with the correct rdata.
- Requests during clear: a_req=1 while busy -> a_gnt=0 for all 32 cycles, then a_gnt=1 on the first SERVE cycle.
- Reset mid-read: reset asserted one cycle after an A read transfer -> a_rvalid never asserts; busy restarts; mem_addr restarts at 0.

Source files
------------

// File: rtl/ram_share_pkg.sv
// Shared constants and types for the two-client ram32x4 sharing controller.
package ram_share_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned READ_LAT = 2;

  typedef enum logic {CLEAR, SERVE} state_t;
  typedef enum logic {CLI_A, CLI_B} client_t;

  typedef struct packed {
    logic    valid;
    client_t cli;
  } rtag_t;

endpackage

// File: rtl/ram_share_ctrl_if.sv
// Client-side bus of the RAM sharing controller: two request ports plus shared read data.
interface ram_share_ctrl_if;
  import ram_share_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic              a_gnt;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_din;
  logic              b_gnt;
  logic              b_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output a_req, a_we, a_addr, a_din,
    output b_req, b_we, b_addr, b_din,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    input  b_req, b_we, b_addr, b_din,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, busy
  );

endinterface

// File: rtl/ram32x4.sv
// 32x4 single-port RAM: address/data/wren sampled on the clock edge, q registered.
module ram32x4
  import ram_share_pkg::*;
(
  input  logic [ADDR_W-1:0] address,
  input  logic              clock,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wren) mem_q[address] <= data;
    q <= mem_q[address];
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the winner only when a grant is used.
module rr_arb2
  import ram_share_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  client_t prio_q, prio_d;

  always_ff @(posedge clk) begin
    if (reset) prio_q <= CLI_A;
    else       prio_q <= prio_d;
  end

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || prio_q == CLI_A)) gnt[0] = 1'b1;
    else if (req[1])                            gnt[1] = 1'b1;
  end

  always_comb begin
    prio_d = prio_q;
    if (advance) prio_d = gnt[0] ? CLI_B : CLI_A;
  end

endmodule

// File: rtl/ram_share_ctrl.sv
// Shares one ram32x4 between clients A and B: clears the RAM after reset, then
// grants one round-robin access per cycle and tags read returns with their owner.
module ram_share_ctrl
  import ram_share_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ram_share_ctrl_if.slave   cif,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  rtag_t             rpipe_q [READ_LAT];
  rtag_t             rtag_d;
  logic [1:0]        arb_gnt;
  logic              a_win, b_win, transfer;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({cif.b_req, cif.a_req}),
    .advance (transfer),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is one bit wider than the address so reaching DEPTH ends CLEAR without wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(DEPTH)) state_d = SERVE;
    end
  end

  always_comb begin
    a_win      = (state_q == SERVE) && arb_gnt[0];
    b_win      = (state_q == SERVE) && arb_gnt[1];
    transfer   = a_win || b_win;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rtag_d     = '{valid: 1'b0, cli: CLI_A};
    if (state_q == CLEAR) begin
      mem_we_d   = 1'b1;
      mem_addr_d = cnt_q[ADDR_W-1:0];
      mem_din_d  = '0;
    end else if (b_win) begin
      mem_we_d   = cif.b_we;
      mem_addr_d = cif.b_addr;
      mem_din_d  = cif.b_din;
      rtag_d     = '{valid: !cif.b_we, cli: CLI_B};
    end else if (a_win) begin
      mem_we_d   = cif.a_we;
      mem_addr_d = cif.a_addr;
      mem_din_d  = cif.a_din;
      rtag_d     = '{valid: !cif.a_we, cli: CLI_A};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) rpipe_q[i] <= '{valid: 1'b0, cli: CLI_A};
    end else begin
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rpipe_q[0] <= rtag_d;
      for (int unsigned i = 1; i < READ_LAT; i++) rpipe_q[i] <= rpipe_q[i-1];
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign cif.a_gnt    = a_win;
  assign cif.b_gnt    = b_win;
  assign cif.a_rvalid = rpipe_q[READ_LAT-1].valid && (rpipe_q[READ_LAT-1].cli == CLI_A);
  assign cif.b_rvalid = rpipe_q[READ_LAT-1].valid && (rpipe_q[READ_LAT-1].cli == CLI_B);
  assign cif.rdata    = mem_dout;
  assign cif.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Directed bench for ram_share_ctrl driving a real ram32x4; flags = {a_gnt, b_gnt, a_rvalid, b_rvalid}.
module tb_ram_share_ctrl;
  import ram_share_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_we;
  int                vec  = 0;
  int                miss = 0;

  ram_share_ctrl_if bus ();

  ram_share_ctrl u_dut (
    .clk      (clk),
    .reset    (reset),
    .cif      (bus),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  ram32x4 u_ram (
    .address (mem_addr),
    .clock   (clk),
    .data    (mem_din),
    .wren    (mem_we),
    .q       (mem_dout)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] din);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_din = din;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] din);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_din = din;
  endtask

  function automatic logic [3:0] flags();
    return {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid};
  endfunction

  task automatic test_reset;
    logic [9:0] exp_m;
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 5'd0, 4'd0);
    drive_b(1'b0, 1'b0, 5'd0, 4'd0);
    repeat (2) next_cycle;
    @(negedge clk);
    vec++;
    if ({bus.busy, flags(), mem_we, mem_addr, mem_din} !== {1'b1, 4'b0000, 1'b0, 5'd0, 4'd0}) begin
      miss++;
      $display("FAIL reset_state: got busy=%b flags=%b we=%b addr=%0d din=%0d want busy=1 flags=0000 we=0 addr=0 din=0",
               bus.busy, flags(), mem_we, mem_addr, mem_din);
    end
    next_cycle;
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      vec++;
      if ({bus.busy, flags()} !== 5'b1_0000) begin
        miss++;
        $display("FAIL clear_busy[%0d]: got busy=%b flags=%b want busy=1 flags=0000", k, bus.busy, flags());
      end
      exp_m = (k == 0) ? 10'd0 : {1'b1, 5'(k - 1), 4'd0};
      vec++;
      if ({mem_we, mem_addr, mem_din} !== exp_m) begin
        miss++;
        $display("FAIL clear_mem[%0d]: got we/addr/din=%b/%0d/%0d want %b/%0d/%0d", k, mem_we, mem_addr,
                 mem_din, exp_m[9], exp_m[8:4], exp_m[3:0]);
      end
      next_cycle;
    end
    drive_a(1'b1, 1'b0, 5'd17, 4'd0);
    @(negedge clk);
    vec++;
    if ({bus.busy, flags(), mem_we, mem_addr} !== {1'b0, 4'b1000, 1'b1, 5'd31}) begin
      miss++;
      $display("FAIL clear_end: got busy=%b flags=%b we=%b addr=%0d want busy=0 flags=1000 we=1 addr=31",
               bus.busy, flags(), mem_we, mem_addr);
    end
    next_cycle;
    drive_a(1'b0, 1'b0, 5'd0, 4'd0);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b0000) begin
      miss++; $display("FAIL read17_gap: got flags=%b want 0000", flags());
    end
    next_cycle;
    @(negedge clk);
    vec++;
    if ({flags(), bus.rdata} !== {4'b0010, 4'd0}) begin
      miss++; $display("FAIL read17_ret: got flags=%b rdata=%0d want 0010 rdata=0", flags(), bus.rdata);
    end
    next_cycle;
  endtask

  task automatic test_single_client;
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] dat   [3];
    logic [3:0]        exp_f;
    addrs[0] = 5'd17; addrs[1] = 5'd25; addrs[2] = 5'd13;
    dat[0]   = 4'd10; dat[1]   = 4'd9;  dat[2]   = 4'd4;
    for (int c = 0; c < 3; c++) begin
      drive_a(1'b1, 1'b1, addrs[c], dat[c]);
      @(negedge clk);
      vec++;
      if (flags() !== 4'b1000) begin
        miss++; $display("FAIL single_wr_gnt[%0d]: got flags=%b want 1000", c, flags());
      end
      next_cycle;
    end
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive_a(1'b1, 1'b0, addrs[c], 4'd0);
      else       drive_a(1'b0, 1'b0, 5'd0, 4'd0);
      @(negedge clk);
      exp_f = {c < 3, 1'b0, c >= 2 && c < 5, 1'b0};
      vec++;
      if (flags() !== exp_f) begin
        miss++; $display("FAIL single_rd_flags[%0d]: got %b want %b", c, flags(), exp_f);
      end
      if (c >= 2 && c < 5) begin
        vec++;
        if (bus.rdata !== dat[c-2]) begin
          miss++; $display("FAIL single_rd_data[%0d]: got %0d want %0d", c, bus.rdata, dat[c-2]);
        end
      end
      next_cycle;
    end
  endtask

  task automatic test_contention;
    drive_b(1'b1, 1'b0, 5'd27, 4'd0);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b0100) begin
      miss++; $display("FAIL cont_b_first: got flags=%b want 0100", flags());
    end
    next_cycle;
    drive_a(1'b1, 1'b1, 5'd27, 4'd5);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b1000) begin
      miss++; $display("FAIL cont_a_win: got flags=%b want 1000", flags());
    end
    next_cycle;
    drive_a(1'b1, 1'b1, 5'd28, 4'd7);
    @(negedge clk);
    vec++;
    if ({flags(), bus.rdata} !== {4'b0101, 4'd0}) begin
      miss++; $display("FAIL cont_b_win: got flags=%b rdata=%0d want 0101 rdata=0", flags(), bus.rdata);
    end
    next_cycle;
    drive_b(1'b0, 1'b0, 5'd0, 4'd0);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b1000) begin
      miss++; $display("FAIL cont_a_second: got flags=%b want 1000", flags());
    end
    next_cycle;
    drive_a(1'b0, 1'b0, 5'd0, 4'd0);
    @(negedge clk);
    vec++;
    if ({flags(), bus.rdata} !== {4'b0001, 4'd5}) begin
      miss++; $display("FAIL cont_b_data: got flags=%b rdata=%0d want 0001 rdata=5", flags(), bus.rdata);
    end
    next_cycle;
    @(negedge clk);
    vec++;
    if (flags() !== 4'b0000) begin
      miss++; $display("FAIL cont_idle: got flags=%b want 0000", flags());
    end
    next_cycle;
  endtask

  task automatic test_tagging;
    logic [3:0] exp_f;
    drive_a(1'b1, 1'b1, 5'd1, 4'd11);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b1000) begin
      miss++; $display("FAIL tag_wr1: got flags=%b want 1000", flags());
    end
    next_cycle;
    drive_a(1'b1, 1'b1, 5'd6, 4'd15);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b1000) begin
      miss++; $display("FAIL tag_wr6: got flags=%b want 1000", flags());
    end
    next_cycle;
    drive_a(1'b1, 1'b0, 5'd1, 4'd0);
    drive_b(1'b1, 1'b0, 5'd6, 4'd0);
    for (int c = 0; c < 7; c++) begin
      if (c == 4) begin
        drive_a(1'b0, 1'b0, 5'd0, 4'd0);
        drive_b(1'b0, 1'b0, 5'd0, 4'd0);
      end
      @(negedge clk);
      exp_f = {c < 4 && c % 2 == 1, c < 4 && c % 2 == 0,
               c >= 2 && c < 6 && c % 2 == 1, c >= 2 && c < 6 && c % 2 == 0};
      vec++;
      if (flags() !== exp_f) begin
        miss++; $display("FAIL tag_flags[%0d]: got %b want %b", c, flags(), exp_f);
      end
      if (c >= 2 && c < 6) begin
        vec++;
        if (bus.rdata !== ((c % 2 == 0) ? 4'd15 : 4'd11)) begin
          miss++; $display("FAIL tag_data[%0d]: got %0d want %0d", c, bus.rdata, (c % 2 == 0) ? 15 : 11);
        end
      end
      next_cycle;
    end
  endtask

  task automatic test_clear_requests;
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 5'd0, 4'd0);
    next_cycle;
    @(negedge clk);
    vec++;
    if ({bus.busy, bus.a_gnt} !== 2'b10) begin
      miss++; $display("FAIL creq_in_reset: got busy=%b a_gnt=%b want busy=1 a_gnt=0", bus.busy, bus.a_gnt);
    end
    next_cycle;
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      vec++;
      if ({bus.busy, bus.a_gnt} !== 2'b10) begin
        miss++; $display("FAIL creq_clear[%0d]: got busy=%b a_gnt=%b want busy=1 a_gnt=0", k, bus.busy, bus.a_gnt);
      end
      next_cycle;
    end
    @(negedge clk);
    vec++;
    if ({bus.busy, bus.a_gnt} !== 2'b01) begin
      miss++; $display("FAIL creq_first_serve: got busy=%b a_gnt=%b want busy=0 a_gnt=1", bus.busy, bus.a_gnt);
    end
    next_cycle;
    drive_a(1'b0, 1'b0, 5'd0, 4'd0);
    next_cycle;
    @(negedge clk);
    vec++;
    if ({flags(), bus.rdata} !== {4'b0010, 4'd0}) begin
      miss++; $display("FAIL creq_ret: got flags=%b rdata=%0d want 0010 rdata=0", flags(), bus.rdata);
    end
    next_cycle;
  endtask

  task automatic test_reset_mid_read;
    drive_a(1'b1, 1'b1, 5'd17, 4'd10);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b1000) begin
      miss++; $display("FAIL mid_wr: got flags=%b want 1000", flags());
    end
    next_cycle;
    drive_a(1'b1, 1'b0, 5'd17, 4'd0);
    @(negedge clk);
    vec++;
    if (flags() !== 4'b1000) begin
      miss++; $display("FAIL mid_rd_gnt: got flags=%b want 1000", flags());
    end
    next_cycle;
    drive_a(1'b0, 1'b0, 5'd0, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if ({flags(), mem_addr} !== {4'b0000, 5'd17}) begin
      miss++; $display("FAIL mid_pre_reset: got flags=%b addr=%0d want 0000 addr=17", flags(), mem_addr);
    end
    next_cycle;
    reset = 1'b0;
    @(negedge clk);
    vec++;
    if ({flags(), bus.busy, mem_we, mem_addr} !== {4'b0000, 1'b1, 1'b0, 5'd0}) begin
      miss++;
      $display("FAIL mid_dropped: got flags=%b busy=%b we=%b addr=%0d want 0000 busy=1 we=0 addr=0",
               flags(), bus.busy, mem_we, mem_addr);
    end
    next_cycle;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      vec++;
      if ({bus.a_rvalid, bus.busy} !== 2'b01) begin
        miss++; $display("FAIL mid_clear[%0d]: got a_rvalid=%b busy=%b want 0 1", k, bus.a_rvalid, bus.busy);
      end
      next_cycle;
    end
    drive_a(1'b1, 1'b0, 5'd17, 4'd0);
    @(negedge clk);
    vec++;
    if ({bus.busy, flags()} !== 5'b0_1000) begin
      miss++; $display("FAIL mid_reserve: got busy=%b flags=%b want busy=0 flags=1000", bus.busy, flags());
    end
    next_cycle;
    drive_a(1'b0, 1'b0, 5'd0, 4'd0);
    next_cycle;
    @(negedge clk);
    vec++;
    if ({flags(), bus.rdata} !== {4'b0010, 4'd0}) begin
      miss++; $display("FAIL mid_recleared: got flags=%b rdata=%0d want 0010 rdata=0", flags(), bus.rdata);
    end
    next_cycle;
  endtask

  initial begin
    test_reset();
    test_single_client();
    test_contention();
    test_tagging();
    test_clear_requests();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
